// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM interface.
package arm_mem_pkg;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_state_t;

   localparam logic [31:0] DEFAULT_MEM_BASE = 32'd1024;
   localparam int unsigned SRAM_AW          = 18;
   localparam int unsigned SRAM_DW          = 16;

endpackage

// File: rtl/sram_controller.sv
// Performs one 32-bit pipeline load/store as two half-word accesses on a 16-bit async SRAM,
// holding ready low (pipeline freeze) for a fixed 2*WAIT_CYCLES+1 clocks per request.
module sram_controller
   import arm_mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] MEM_BASE    = DEFAULT_MEM_BASE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic [SRAM_DW-1:0] SRAM_DQ_out,
   output logic               SRAM_DQ_oe,
   input  logic [SRAM_DW-1:0] SRAM_DQ_in,
   output logic               SRAM_WE_N
);

   localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

   sram_state_t state_q;
   logic [3:0]  cnt_q;
   logic        wr_q;
   logic [31:0] buf_q;
   logic [31:0] read_data_q;

   logic        req;
   logic        last;
   logic        half;
   logic [16:0] word;

   assign req  = rd_en | wr_en;
   assign last = (cnt_q == LastCnt);
   assign half = (state_q == HI);
   assign word = 17'((address - MEM_BASE) >> 2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         buf_q       <= 32'd0;
         read_data_q <= 32'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  wr_q    <= wr_en;
                  cnt_q   <= 4'd0;
                  state_q <= LO;
               end
            end
            LO, HI: begin
               // Read data is taken on the last phase cycle, after the full access time.
               if (!wr_q && last) begin
                  if (half) buf_q[31:16] <= SRAM_DQ_in;
                  else      buf_q[15:0]  <= SRAM_DQ_in;
               end
               if (last) begin
                  cnt_q   <= 4'd0;
                  state_q <= half ? DONE : HI;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            DONE: begin
               if (!wr_q) read_data_q <= buf_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      SRAM_ADDR   = '0;
      SRAM_DQ_out = '0;
      SRAM_DQ_oe  = 1'b0;
      SRAM_WE_N   = 1'b1;
      if (state_q == LO || state_q == HI) begin
         SRAM_ADDR = {word, half};
         if (wr_q) begin
            SRAM_DQ_oe  = 1'b1;
            SRAM_DQ_out = half ? write_data[31:16] : write_data[15:0];
            // Strobe released on the final phase cycle so data/address are held past WE_N rise.
            SRAM_WE_N   = last && (WAIT_CYCLES > 1);
         end
      end
   end

   always_comb begin
      unique case (state_q)
         IDLE:    ready = ~req;
         DONE:    ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign read_data = read_data_q;

endmodule
